// File: rtl/ifu_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, the redirect source and decode.
// The master modport is the fetch queue's own view of the bundle.
interface ifu_fetch_queue_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_inst;
  logic            out_valid;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;
  logic [CntW-1:0] occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_inst,
           out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_inst,
           out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, occupancy
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Decoupled fetch front-end: credit-limited sequential imem requests, in-order response FIFO
// tagged with PCs, and redirect handling that discards responses still in flight.
module ifu_fetch_queue #(
  parameter int unsigned    XLEN      = 64,
  parameter int unsigned    ILEN      = 32,
  parameter int unsigned    DEPTH     = 4,
  parameter int unsigned    MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input logic                clk,
  input logic                rst,
  ifu_fetch_queue_if.master  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   sum_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t            occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;

  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic            credit_ok, req_fire, resp_fire, drop_resp, push, pop;
  sum_t            inflight_sum;
  logic [XLEN-1:0] redirect_base;

  always_comb begin
    inflight_sum  = sum_t'(occ_q) + sum_t'(outst_q);
    credit_ok     = (outst_q < cnt_t'(MAX_OUTST)) && (inflight_sum < sum_t'(DEPTH));
    redirect_base = bus.redirect_pc & ~XLEN'(3);
    // Gating with rst keeps the request low while reset is held.
    bus.imem_req_valid = rst && !bus.redirect_valid && credit_ok;
    bus.imem_req_addr  = fetch_pc_q;
    req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    resp_fire = bus.imem_resp_valid;
    drop_resp = drop_q != '0;
    push      = resp_fire && !bus.redirect_valid && !drop_resp;
    pop       = (occ_q != '0) && bus.out_ready && !bus.redirect_valid;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    outst_d    = outst_q + cnt_t'(req_fire) - cnt_t'(resp_fire);
    drop_d     = drop_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      // Every request still in flight after this cycle is stale.
      drop_d     = outst_q - cnt_t'(resp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
      if (resp_fire && drop_resp) drop_d = drop_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.imem_resp_inst;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign bus.out_valid = occ_q != '0;
  assign bus.out_inst  = bus.out_valid ? inst_mem[rd_ptr_q] : '0;
  assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.occupancy = occ_q;

  // Last popped PC, kept only to check PC continuity across pops.
  logic [XLEN-1:0] last_pc_q;
  logic            last_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      last_vld_q <= 1'b0;
    end else if (pop) begin
      last_pc_q  <= bus.out_pc;
      last_vld_q <= 1'b1;
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (!rst) inflight_sum <= sum_t'(DEPTH));
  a_drop: assert property (@(posedge clk) disable iff (!rst) drop_q <= outst_q);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && occ_q == cnt_t'(DEPTH)));
  a_resp_has_req: assert property (@(posedge clk) disable iff (!rst)
    !(resp_fire && outst_q == '0));
  a_pc_seq: assert property (@(posedge clk) disable iff (!rst)
    (pop && last_vld_q) |-> (bus.out_pc == last_pc_q + XLEN'(4)));
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Randomised bench for ifu_fetch_queue: a queue-based reference model predicts every output
// each cycle, and a small instruction-memory stub answers accepted requests in order.
module tb_ifu_fetch_queue;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned ILEN      = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [63:0] RESET_PC  = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  ifu_fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  typedef struct {logic [63:0] addr; int epoch;} infl_t;
  typedef struct {logic [63:0] addr; int due;} pend_t;

  // Reference model: queue of delivered PCs, queue of in-flight requests tagged by epoch.
  logic [63:0] m_fifo[$];
  infl_t       m_infl[$];
  logic [63:0] m_fetch_pc;
  int          m_epoch;
  pend_t       mem_q[$];
  logic [63:0] pops[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int max_occ  = 0;
  int k_ready  = 0;  // 0 always high, 1 toggle, 2 random
  int k_oready = 1;  // 0 low, 1 high, 2 random
  int k_lat    = 1;  // 0 random 1..3
  int k_redir  = 0;  // 0 none, else 1-in-k chance
  logic tog = 1'b0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5a5a_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_infl.delete();
    mem_q.delete();
    m_fetch_pc = RESET_PC;
    m_epoch    = 0;
  endtask

  task automatic compare();
    logic exp_rv;
    exp_rv = rst_n && !bus.redirect_valid && (m_infl.size() < int'(MAX_OUTST)) &&
             (m_fifo.size() + m_infl.size() < int'(DEPTH));
    chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    chk("req_addr", bus.imem_req_addr, m_fetch_pc);
    chk("occupancy", 64'(bus.occupancy), 64'(m_fifo.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(m_fifo.size() != 0));
    if (m_fifo.size() > 0) begin
      chk("out_pc", bus.out_pc, m_fifo[0]);
      chk("out_inst", 64'(bus.out_inst), 64'(inst_of(m_fifo[0])));
    end
    if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
    if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid)
      pops.push_back(bus.out_pc);
  endtask

  task automatic model_step();
    logic  rv, acc, pop;
    infl_t r;
    rv  = bus.redirect_valid;
    acc = !rv && (m_infl.size() < int'(MAX_OUTST)) &&
          (m_fifo.size() + m_infl.size() < int'(DEPTH)) && bus.imem_req_ready;
    pop = !rv && (m_fifo.size() > 0) && bus.out_ready;
    if (pop) void'(m_fifo.pop_front());
    if (bus.imem_resp_valid && m_infl.size() > 0) begin
      r = m_infl.pop_front();
      if (!rv && r.epoch == m_epoch) m_fifo.push_back(r.addr);
    end
    if (rv) begin
      m_fifo.delete();
      m_epoch++;
      m_fetch_pc = {bus.redirect_pc[63:2], 2'b00};
    end
    if (acc) begin
      r.addr  = m_fetch_pc;
      r.epoch = m_epoch;
      m_infl.push_back(r);
      m_fetch_pc = m_fetch_pc + 64'd4;
    end
  endtask

  task automatic mem_step(input logic acc, input logic [63:0] addr);
    pend_t p;
    if (bus.imem_resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (acc) begin
      p.addr = addr;
      p.due  = cyc + ((k_lat == 0) ? int'($urandom_range(3, 1)) : k_lat);
      mem_q.push_back(p);
    end
  endtask

  task automatic drive_inputs();
    case (k_ready)
      0: bus.imem_req_ready = 1'b1;
      1: begin tog = ~tog; bus.imem_req_ready = tog; end
      default: bus.imem_req_ready = 1'($urandom_range(1, 0));
    endcase
    case (k_oready)
      0: bus.out_ready = 1'b0;
      1: bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(1, 0));
    endcase
    bus.redirect_valid = 1'b0;
    if (k_redir != 0 && $urandom_range(k_redir - 1, 0) == 0) begin
      bus.redirect_valid = 1'b1;
      if ($urandom_range(7, 0) == 0) bus.redirect_pc = 64'hffff_ffff_ffff_fff0 | 64'($urandom_range(15, 0));
      else bus.redirect_pc = {32'h0, $urandom()};
    end
    if (rst_n) begin
      bus.imem_resp_valid = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      bus.imem_resp_inst  = bus.imem_resp_valid ? inst_of(mem_q[0].addr) : $urandom();
    end else begin
      bus.imem_resp_valid = 1'($urandom_range(1, 0));
      bus.imem_resp_inst  = $urandom();
    end
  endtask

  task automatic step();
    logic        acc_s;
    logic [63:0] addr_s;
    @(negedge clk);
    compare();
    acc_s  = bus.imem_req_valid && bus.imem_req_ready;
    addr_s = bus.imem_req_addr;
    @(posedge clk);
    if (rst_n) begin
      model_step();
      mem_step(acc_s, addr_s);
    end
    cyc++;
    #1 drive_inputs();
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    pops.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    release_rst();
  endtask

  initial begin
    int   bad;
    logic found;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Streaming with single-cycle memory.
    repeat (2) step();
    release_rst();
    max_occ = 0;
    repeat (30) step();
    chk("stream_pc0", (pops.size() > 0) ? pops[0] : '0, 64'h8000_0000);
    chk("stream_pc1", (pops.size() > 1) ? pops[1] : '0, 64'h8000_0004);
    chk("stream_pc2", (pops.size() > 2) ? pops[2] : '0, 64'h8000_0008);
    chk("stream_throughput", 64'(pops.size()), 64'd28);
    chk("stream_occ_le1", 64'(max_occ <= 1), 64'd1);

    // Stall until full, then drain.
    k_oready = 0;
    do_reset();
    repeat (10) step();
    #2;
    chk("stall_occ", 64'(bus.occupancy), 64'd4);
    chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("stall_req_addr", bus.imem_req_addr, 64'h8000_0010);
    chk("stall_head_pc", bus.out_pc, 64'h8000_0000);
    k_oready = 1;
    repeat (20) step();
    chk("drain_first_pc", (pops.size() > 0) ? pops[0] : '0, 64'h8000_0000);

    // Redirect with two requests outstanding, 3-cycle memory.
    k_lat = 3;
    do_reset();
    repeat (2) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0100;
    pops.delete();
    repeat (16) step();
    chk("redir_first_pc", (pops.size() > 0) ? pops[0] : '0, 64'h8000_0100);
    bad = 0;
    foreach (pops[i]) if (pops[i] < 64'h8000_0100) bad++;
    chk("redir_no_stale", 64'(bad), 64'd0);

    // Redirect coinciding with a response and a pop.
    k_lat = 2;
    k_oready = 2;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = bus.imem_resp_valid && (m_fifo.size() > 0);
    end
    chk("coinc_setup_found", 64'(found), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h8000_0203;
    bus.out_ready = 1'b1;
    k_oready = 1;
    pops.delete();
    step();
    #2;
    chk("coinc_occ_zero", 64'(bus.occupancy), 64'd0);
    chk("coinc_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (15) step();
    chk("coinc_first_pc", (pops.size() > 0) ? pops[0] : '0, 64'h8000_0200);

    // Random backpressure, back-to-back redirects, random latency.
    k_ready = 2; k_oready = 2; k_lat = 0; k_redir = 0;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_0000_1000;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_0000_2002;
    k_redir = 16;
    repeat (600) step();
    k_ready = 1;
    repeat (100) step();

    // Asynchronous reset mid-stream at occupancy 3.
    k_ready = 0; k_oready = 0; k_lat = 1; k_redir = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = m_fifo.size() == 3;
    end
    chk("arst_setup_occ3", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_occ", 64'(bus.occupancy), 64'd0);
    repeat (3) step();
    k_oready = 1;
    release_rst();
    bus.out_ready = 1'b1;
    repeat (20) step();
    chk("arst_restart_pc", (pops.size() > 0) ? pops[0] : '0, 64'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
